display_frame_ctrl: RTL
=======================

# display_frame_ctrl

Frame-synchronous update controller between the game logic and the VGA display path. The game logic hands over a new board/brick/state snapshot through a req/ack handshake. The block buffers one pending snapshot and commits it to the display inputs only at the start of vertical blanking, so the display never tears mid-frame. On a game-state change it blanks the screen for a programmable number of frames. It also provides a per-frame tick and a frame counter for gravity and animation timing.

## Interface
Parameters:
- BLANK_FRAMES, 2: frames of forced black after a committed state change; 0 disables blanking.
- FRAME_CNT_W, 16: width of the frame counter.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  reset, asynchronous, active-low.
- vsync  in  1  VGA vsync from the display's VGA timing generator (25 MHz pixel domain derived from clk); active-low pulse.
- upd_req  in  1  game logic requests a snapshot handover; level signal.
- upd_board  in  `BOARD_SIZE  board bitmap to hand over.
- upd_brick_type  in  `BRICK_LEN  current brick type.
- upd_brick_pos  in  `BRICK_POS_LEN  current brick position.
- upd_shadow_pos  in  `BRICK_POS_LEN  shadow brick position.
- upd_state  in  `STATE_LEN  game state (`START/`PLAYING/...).
- upd_ack  out  1  one-cycle pulse: snapshot captured.
- disp_board  out  `BOARD_SIZE  committed board, feeds display.
- disp_brick_type  out  `BRICK_LEN  committed brick type.
- disp_brick_pos  out  `BRICK_POS_LEN  committed brick position.
- disp_shadow_pos  out  `BRICK_POS_LEN  committed shadow position.
- disp_state  out  `STATE_LEN  committed state.
- blank  out  1  force display output black.
- frame_tick  out  1  one-cycle pulse per frame.
- frame_cnt  out  FRAME_CNT_W  frames since reset; wraps at 2^FRAME_CNT_W.

## Operation
- Reset (rst=0, async): disp_* = 0 except disp_state=`START; blank=0, upd_ack=0, frame_tick=0, frame_cnt=0, pending buffer empty, blank_cnt=0.
- vsync is passed through a 2-flop synchronizer; a falling edge of the synchronized value is the frame edge (fe).
- Capture: on a rising clk edge where upd_req=1, pending empty and fe=0, the upd_* fields are latched into pending and marked full. upd_ack=1 for exactly the following cycle.
- The requester holds upd_req and its data stable until it sees upd_ack, then deasserts upd_req for at least one cycle. upd_req still high in the cycle after ack is treated as a new request.
- Pending full: no ack is given; the request stalls until the next fe drains the buffer. Worst-case wait is one frame plus 1 cycle.
- Frame edge (fe=1), on the same clk edge:
  - frame_tick is set (high for 1 cycle) and frame_cnt increments.
  - If pending is full, pending is copied to disp_* and pending becomes empty.
  - Capture is inhibited on the fe cycle; a waiting request is captured on the next cycle.
- Blank FSM, two states:
  - SHOW (blank=0): at a commit with pending.state != disp_state and BLANK_FRAMES>0, go to BLANK and load blank_cnt=BLANK_FRAMES.
  - BLANK (blank=1): each later fe decrements blank_cnt. The fe that decrements it from 1 to 0 returns the FSM to SHOW.
  - A commit during BLANK with another state change reloads blank_cnt=BLANK_FRAMES.
  - Commits still update disp_* while in BLANK.
- A commit with an unchanged state never blanks.

## Timing
- vsync fall sampled at clk edge k, then fe is high during the cycle after edge k+2. At edge k+3, disp_*, frame_cnt and the FSM update and frame_tick rises; frame_tick falls at edge k+4.
- Capture latency: upd_req seen at edge n (buffer empty, no fe) gives upd_ack high from edge n to n+1.
- All outputs are registered; there is no combinational input-to-output path.
- A reset asserted mid-handshake or mid-blank returns every output to its reset value immediately. Any pending snapshot is discarded and the requester must re-request.

## Structure
- `BOARD_SIZE, `BRICK_LEN, `BRICK_POS_LEN, `STATE_LEN, `START and `PLAYING come from the shared header.v. Add `BLANK_FRAMES_DEFAULT there.
- Sub-module vsync_edge_det: 2-flop synchronizer plus falling-edge detector, async active-low reset, output fe.
- The top integrates between the game FSM and display; display's vgaRed/Green/Blue are gated to 0 when blank=1.

## Test plan
- Reset: hold rst=0 with upd_req=1 and vsync toggling -> all outputs at reset values, disp_state=`START, no ack.
- Basic handover: upd_req with board=0x...A5, state=`START, then one vsync fall -> ack 1 cycle after req; disp_board=0x...A5 at edge k+3 with frame_tick pulse; blank stays 0.
- Back-pressure: second req right after first ack, before vsync -> no ack until the cycle after fe; first snapshot committed, second captured, committed on the following frame.
- State change: commit `PLAYING while disp_state=`START, BLANK_FRAMES=2 -> blank=1 for exactly 2 frame edges, then 0; disp_state=`PLAYING from the first commit.
- Simultaneous: upd_req rising on the fe cycle with pending empty -> no capture that cycle, ack one cycle later, commit on the next frame.
- Wrap and reset mid-op: FRAME_CNT_W=4, 17 vsync falls -> frame_cnt=1. Assert rst during BLANK -> blank=0 and pending empty immediately.

Source files
------------

// File: rtl/display_frame_ctrl_pkg.sv
// display_frame_ctrl_pkg: shared game/display widths, state codes and snapshot type for the frame controller.
package display_frame_ctrl_pkg;
  localparam int BOARD_SIZE = 200;
  localparam int BRICK_LEN = 3;
  localparam int BRICK_POS_LEN = 8;
  localparam int STATE_LEN = 2;
  localparam int BLANK_FRAMES_DEFAULT = 2;
  localparam logic [STATE_LEN-1:0] START = 2'd1;
  localparam logic [STATE_LEN-1:0] PLAYING = 2'd2;
  localparam logic [STATE_LEN-1:0] GAME_OVER = 2'd3;
  localparam logic [0:0] S_SHOW = 1'b0;
  localparam logic [0:0] S_BLANK = 1'b1;
  typedef struct packed {
    logic [BOARD_SIZE-1:0] board;
    logic [BRICK_LEN-1:0] brick_type;
    logic [BRICK_POS_LEN-1:0] brick_pos;
    logic [BRICK_POS_LEN-1:0] shadow_pos;
    logic [STATE_LEN-1:0] state;
  } snapshot_t;
  localparam snapshot_t RESET_SNAP = '{board: '0, brick_type: '0, brick_pos: '0, shadow_pos: '0, state: START};
  function automatic logic needs_blank(snapshot_t nxt, logic [STATE_LEN-1:0] cur, int frames);
    return (frames > 0) && (nxt.state != cur);
  endfunction
endpackage

// File: rtl/display_frame_ctrl_vsync_edge_det.sv
// vsync_edge_det: two-flop vsync synchronizer with a registered falling-edge pulse (fe).
module vsync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic fe
);
  logic [1:0] sync;
  logic prev;
  // Flops reset high (vsync idle level) so leaving reset never fakes a frame edge.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync <= 2'b11;
      prev <= 1'b1;
      fe <= 1'b0;
    end else begin
      sync <= {sync[0], vsync};
      prev <= sync[1];
      fe <= prev & ~sync[1];
    end
endmodule

// File: rtl/display_frame_ctrl.sv
// display_frame_ctrl: buffers one game snapshot and commits it at vertical blanking, with state-change blanking and frame timing.
module display_frame_ctrl
  import display_frame_ctrl_pkg::*;
#(
  parameter int BLANK_FRAMES = BLANK_FRAMES_DEFAULT,
  parameter int FRAME_CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic upd_req,
  input  logic [BOARD_SIZE-1:0] upd_board,
  input  logic [BRICK_LEN-1:0] upd_brick_type,
  input  logic [BRICK_POS_LEN-1:0] upd_brick_pos,
  input  logic [BRICK_POS_LEN-1:0] upd_shadow_pos,
  input  logic [STATE_LEN-1:0] upd_state,
  output logic upd_ack,
  output logic [BOARD_SIZE-1:0] disp_board,
  output logic [BRICK_LEN-1:0] disp_brick_type,
  output logic [BRICK_POS_LEN-1:0] disp_brick_pos,
  output logic [BRICK_POS_LEN-1:0] disp_shadow_pos,
  output logic [STATE_LEN-1:0] disp_state,
  output logic blank,
  output logic frame_tick,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);
  localparam int CNT_W = $clog2(BLANK_FRAMES + 2);
  logic fe;
  logic capture;
  logic commit;
  logic pend_full;
  logic [0:0] fsm;
  logic [CNT_W-1:0] blank_cnt;
  snapshot_t snap_in;
  snapshot_t pend;
  snapshot_t disp;

  vsync_edge_det u_edge (.clk(clk), .rst(rst), .vsync(vsync), .fe(fe));

  assign snap_in = {upd_board, upd_brick_type, upd_brick_pos, upd_shadow_pos, upd_state};
  // Capture is held off on the frame edge so a commit and a new capture never collide.
  assign capture = upd_req & ~pend_full & ~fe;
  assign commit = fe & pend_full;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pend <= '0;
      pend_full <= 1'b0;
      disp <= RESET_SNAP;
      upd_ack <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt <= '0;
      fsm <= S_SHOW;
      blank_cnt <= '0;
    end else begin
      upd_ack <= capture;
      frame_tick <= fe;
      if (fe) frame_cnt <= frame_cnt + 1'b1;
      if (capture) begin
        pend <= snap_in;
        pend_full <= 1'b1;
      end else if (commit) pend_full <= 1'b0;
      if (commit) disp <= pend;
      if (commit && needs_blank(pend, disp.state, BLANK_FRAMES)) begin
        fsm <= S_BLANK;
        blank_cnt <= CNT_W'(BLANK_FRAMES);
      end else if (fe && fsm == S_BLANK) begin
        blank_cnt <= blank_cnt - 1'b1;
        if (blank_cnt == CNT_W'(1)) fsm <= S_SHOW;
      end
    end

  assign disp_board = disp.board;
  assign disp_brick_type = disp.brick_type;
  assign disp_brick_pos = disp.brick_pos;
  assign disp_shadow_pos = disp.shadow_pos;
  assign disp_state = disp.state;
  assign blank = (fsm == S_BLANK);
endmodule
